// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU serial input protocol: packet/frame geometry,
// packet type codes, the host transmitter FSM states and the reference CRC4.
package mtm_alu_pkg;

  localparam int unsigned PKT_BITS   = 11;
  localparam int unsigned FRAME_PKTS = 9;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CTL  = 1'b1;

  // x^4 + x + 1, feedback taps applied after the shift
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StSendB,
    StSendA,
    StSendCtl,
    StGap
  } tx_state_e;

  function automatic logic [3:0] crc4_68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/mtm_alu_pkt_tx.sv
// Single-packet serializer: start bit, type bit, 8 payload bits MSB first, stop bit.
// A load may coincide with the stop bit so packets run back to back.
module mtm_alu_pkt_tx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_type,
  input  logic [7:0] i_payload,
  output logic       o_sout,
  output logic       o_done
);

  logic [9:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_active;
  logic       r_sout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_active  <= 1'b0;
      r_sout    <= 1'b1;
    end else if (i_load) begin
      r_sout    <= 1'b0;
      r_shift   <= {i_type, i_payload, 1'b1};
      r_bit_cnt <= '0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      if (r_bit_cnt == 4'(PKT_BITS - 1)) begin
        r_active  <= 1'b0;
        r_bit_cnt <= '0;
        r_sout    <= 1'b1;
      end else begin
        r_sout    <= r_shift[9];
        r_shift   <= {r_shift[8:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  assign o_sout = r_sout;
  assign o_done = r_active && (r_bit_cnt == 4'(PKT_BITS - 1));

endmodule

// File: rtl/mtm_alu_host_tx.sv
// Host-side ALU frame transmitter: accepts (A, B, OP) on valid/ready and sends
// 4 B packets, 4 A packets and one control packet, then an idle-high gap.
module mtm_alu_host_tx
  import mtm_alu_pkg::*;
#(
  parameter int unsigned IDLE_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        crc_err_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        sout
);

  tx_state_e   r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic        r_crc_err;
  logic [1:0]  r_byte_cnt;
  logic [3:0]  r_gap_cnt;
  logic        r_ready;
  logic        r_busy;

  logic        w_load;
  logic        w_type;
  logic [7:0]  w_payload;
  logic        w_done;
  logic [1:0]  w_byte_nxt;
  logic [3:0]  w_crc;
  logic [7:0]  w_ctl;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign w_byte_nxt = r_byte_cnt + 2'd1;
  assign w_crc      = crc4_68({r_b, r_a, 1'b1, r_op});
  assign w_ctl      = {1'b0, r_op, w_crc ^ {3'b000, r_crc_err}};

  // Loads are combinational so the first start bit leaves on the transfer edge.
  always_comb begin
    w_load    = 1'b0;
    w_type    = TYPE_DATA;
    w_payload = b_i[31:24];
    unique case (r_state)
      StIdle: w_load = valid_i && r_ready;
      StSendB: begin
        w_load    = w_done;
        w_payload = (r_byte_cnt == 2'd3) ? r_a[31:24] : byte_of(r_b, w_byte_nxt);
      end
      StSendA: begin
        w_load = w_done;
        if (r_byte_cnt == 2'd3) begin
          w_type    = TYPE_CTL;
          w_payload = w_ctl;
        end else begin
          w_payload = byte_of(r_a, w_byte_nxt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_crc_err  <= 1'b0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b1;
          if (valid_i && r_ready) begin
            r_a        <= a_i;
            r_b        <= b_i;
            r_op       <= op_i;
            r_crc_err  <= crc_err_i;
            r_byte_cnt <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StSendB;
          end
        end
        StSendB: begin
          if (w_done) begin
            r_byte_cnt <= w_byte_nxt;
            if (r_byte_cnt == 2'd3) r_state <= StSendA;
          end
        end
        StSendA: begin
          if (w_done) begin
            r_byte_cnt <= w_byte_nxt;
            if (r_byte_cnt == 2'd3) r_state <= StSendCtl;
          end
        end
        StSendCtl: begin
          if (w_done) begin
            r_gap_cnt <= '0;
            r_state   <= StGap;
          end
        end
        StGap: begin
          if (r_gap_cnt == 4'(IDLE_BITS - 1)) begin
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  mtm_alu_pkt_tx u_pkt_tx (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_type    (w_type),
    .i_payload (w_payload),
    .o_sout    (sout),
    .o_done    (w_done)
  );

  assign ready_o = r_ready;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_mtm_alu_host_tx.sv
// Scoreboard bench for mtm_alu_host_tx: one instance with IDLE_BITS=2, one with IDLE_BITS=1.
module tb_mtm_alu_host_tx;
  import mtm_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [2:0]  op_i = '0;
  logic        crc_err_i = 1'b0;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic        ready0, busy0, sout0;
  logic        ready1, busy1, sout1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hs0 = 0;
  int hs1 = 0;
  int hs0_t[$];
  int hs1_t[$];
  logic q0[$];
  logic q1[$];
  logic e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mtm_alu_host_tx #(.IDLE_BITS(2)) dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .op_i(op_i), .crc_err_i(crc_err_i),
    .valid_i(valid0), .ready_o(ready0), .busy_o(busy0), .sout(sout0)
  );

  mtm_alu_host_tx #(.IDLE_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .op_i(op_i), .crc_err_i(crc_err_i),
    .valid_i(valid1), .ready_o(ready1), .busy_o(busy1), .sout(sout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [98:0] frame(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic err);
    logic [98:0] f;
    logic [7:0]  by;
    logic [3:0]  crc;
    crc = crc4_68({b, a, 1'b1, op}) ^ {3'b000, err};
    f = '0;
    for (int p = 0; p < 8; p++) begin
      by = (p < 4) ? b[31-8*p -: 8] : a[31-8*(p-4) -: 8];
      f[98-11*p -: 11] = {1'b0, TYPE_DATA, by, 1'b1};
    end
    f[10:0] = {1'b0, TYPE_CTL, 1'b0, op, crc, 1'b1};
    return f;
  endfunction

  task automatic push_frame(input int sel);
    logic [98:0] f;
    f = frame(a_i, b_i, op_i, crc_err_i);
    for (int k = 98; k >= 0; k--) begin
      if (sel == 0) q0.push_back(f[k]);
      else q1.push_back(f[k]);
    end
  endtask

  // Monitors: compare pending frame bits, otherwise expect idle-high line.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check("sout0", 32'(sout0), 32'(e0));
      check("busy0_frame", 32'(busy0), 32'd1);
    end else if (!rst) begin
      check("idle0", 32'(sout0), 32'd1);
      if (ready0) check("busy0_idle", 32'(busy0), 32'd0);
    end
    if (valid0 && ready0 && !rst) begin
      push_frame(0);
      hs0_t.push_back(cyc);
      hs0++;
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("sout1", 32'(sout1), 32'(e1));
      check("busy1_frame", 32'(busy1), 32'd1);
    end else if (!rst) begin
      check("idle1", 32'(sout1), 32'd1);
      if (ready1) check("busy1_idle", 32'(busy1), 32'd0);
    end
    if (valid1 && ready1 && !rst) begin
      push_frame(1);
      hs1_t.push_back(cyc);
      hs1++;
    end
  end

  // Called just after a posedge; returns just after the transfer edge.
  task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic err);
    int prev;
    int n;
    prev = (sel == 0) ? hs0 : hs1;
    a_i = a; b_i = b; op_i = op; crc_err_i = err;
    if (sel == 0) valid0 = 1'b1;
    else valid1 = 1'b1;
    n = 0;
    while ((((sel == 0) ? hs0 : hs1) == prev) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ready0(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ready0 && waited < 400);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic [98:0] f;
    logic [7:0]  by;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sout", 32'(sout0), 32'd1);
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_still_low", 32'(ready0), 32'd0);
    @(negedge clk);
    check("ready_rise", 32'(ready0), 32'd1);
    @(posedge clk); #1;

    // 1: all-zero operation, known CRC and ready return time
    check("crc_zero", 32'(crc4_68(68'h8)), 32'hB);
    f = frame(32'h0, 32'h0, 3'b000, 1'b0);
    by = f[8:1];
    check("ctl_zero", 32'(by), 32'h0B);
    send(0, 32'h0, 32'h0, 3'b000, 1'b0);
    valid0 = 1'b0;
    wait_ready0(w);
    check("ready_return", 32'(cyc - hs0_t[hs0_t.size()-1]), 32'd102);
    @(posedge clk); #1;

    // 2: byte ordering
    f = frame(32'h01234567, 32'h89ABCDEF, 3'b100, 1'b0);
    by = f[96:89];
    check("t2_first_b", 32'(by), 32'h89);
    by = f[52:45];
    check("t2_first_a", 32'(by), 32'h01);
    send(0, 32'h01234567, 32'h89ABCDEF, 3'b100, 1'b0);
    valid0 = 1'b0;
    wait_ready0(w);
    @(posedge clk); #1;

    // 3: forced CRC error
    f = frame(32'h0, 32'h0, 3'b000, 1'b1);
    by = f[8:1];
    check("ctl_crc_err", 32'(by), 32'h0A);
    send(0, 32'h0, 32'h0, 3'b000, 1'b1);
    valid0 = 1'b0;
    wait_ready0(w);
    @(posedge clk); #1;

    // 4: valid held for three operations; a_i changes right after each transfer
    base = hs0_t.size();
    send(0, 32'h11111111, 32'hA5A5A5A5, 3'b001, 1'b0);
    send(0, 32'h22222222, 32'hA5A5A5A5, 3'b010, 1'b0);
    send(0, 32'h33333333, 32'hA5A5A5A5, 3'b101, 1'b0);
    a_i = 32'hDEADBEEF;
    valid0 = 1'b0;
    wait_ready0(w);
    check("t4_period1", 32'(hs0_t[base+1] - hs0_t[base]), 32'd102);
    check("t4_period2", 32'(hs0_t[base+2] - hs0_t[base+1]), 32'd102);
    @(posedge clk); #1;

    // 5: reset during bit 5 of the third B packet (frame bit 27)
    send(0, 32'hCAFEF00D, 32'h12345678, 3'b110, 1'b0);
    valid0 = 1'b0;
    repeat (27) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q0.delete();
    @(negedge clk);
    check("t5_sout", 32'(sout0), 32'd1);
    check("t5_busy", 32'(busy0), 32'd0);
    check("t5_ready_low", 32'(ready0), 32'd0);
    @(negedge clk);
    check("t5_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    send(0, 32'h0F0F0F0F, 32'hF0F0F0F0, 3'b011, 1'b0);
    valid0 = 1'b0;
    wait_ready0(w);
    @(posedge clk); #1;

    // 6: IDLE_BITS=1 instance, random operations back to back
    base = hs1_t.size();
    for (int i = 0; i < 20; i++) begin
      send(1, $urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1)));
    end
    valid1 = 1'b0;
    for (int i = base + 1; i < hs1_t.size(); i++) begin
      check("t6_period", 32'(hs1_t[i] - hs1_t[i-1]), 32'd101);
    end

    w = 0;
    while ((q0.size() > 0 || q1.size() > 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
